turret_servo_ctrl: RTL and testbench



---
 rtl/turret_servo_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_turret_servo_ctrl.sv | 444 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/turret_servo_ctrl.sv
// Turret pan/tilt servo sequencer with APB3 register file.
// Two 50 Hz PWM channels, per-frame slew limiting and a fire/cooldown FSM.
module turret_servo_ctrl #(
  parameter int CLKS_PER_US = 100,
  parameter int FRAME_US    = 20000,
  parameter int MIN_US      = 1000,
  parameter int MAX_US      = 2000,
  parameter int FIRE_US     = 50000,
  parameter int COOL_US     = 500000,
  parameter int TGT_RST     = 1500,
  parameter int STEP_RST    = 10
) (
  input  logic        FAB_CLK,
  input  logic        FAB_RESET,
  input  logic        PSEL,
  input  logic        PENABLE,
  input  logic        PWRITE,
  input  logic [7:0]  PADDR,
  input  logic [31:0] PWDATA,
  output logic [31:0] PRDATA,
  output logic        PREADY,
  output logic        PSLVERR,
  output logic        PAN_PWM,
  output logic        TILT_PWM,
  output logic        FIRE_OUT,
  output logic        IRQ
);

  localparam int PW  = (CLKS_PER_US > 1) ? $clog2(CLKS_PER_US) : 1;
  localparam int FMX = (COOL_US > FIRE_US) ? COOL_US : FIRE_US;
  localparam int FUW = (FMX > 1) ? $clog2(FMX) : 1;

  typedef enum logic [1:0] {IDLE, FIRING, COOLDOWN} fire_st_t;

  logic [2:0]     ctrl;
  logic [15:0]    pan_tgt, tilt_tgt;
  logic [15:0]    pan_cur, tilt_cur;
  logic [15:0]    pan_nxt, tilt_nxt;
  logic [7:0]     step;
  logic           done;
  logic [PW-1:0]  pre;
  logic [14:0]    frame_cnt;
  logic           pan_pwm, tilt_pwm;
  logic [PW-1:0]  fire_pre;
  logic [FUW-1:0] fire_us;
  fire_st_t       state, state_nxt;

  logic        wr, mapped, tick, wrap, upd;
  logic        pan_at, tilt_at, both_at, nxt_both, done_set;
  logic        fire_tick, fire_req, abort, busy;
  logic [5:0]  word;
  logic [31:0] rdata;

  function automatic logic [15:0] clamp(input logic [15:0] v);
    if (v < 16'(MIN_US))      clamp = 16'(MIN_US);
    else if (v > 16'(MAX_US)) clamp = 16'(MAX_US);
    else                      clamp = v;
  endfunction

  function automatic logic [15:0] slew(
    input logic [15:0] cur,
    input logic [15:0] tgt,
    input logic [7:0]  st
  );
    logic signed [16:0] d;
    logic signed [16:0] s;
    d = $signed({1'b0, tgt}) - $signed({1'b0, cur});
    s = $signed({9'd0, st});
    if (st == 8'd0 || (d <= s && d >= -s)) slew = tgt;
    else if (d > s) slew = cur + {8'd0, st};
    else            slew = cur - {8'd0, st};
  endfunction

  assign wr      = PSEL & PENABLE & PWRITE;
  assign word    = PADDR[7:2];
  assign mapped  = (word <= 6'd5);
  assign PREADY  = 1'b1;
  assign PSLVERR = PSEL & PENABLE & ~mapped;

  assign tick     = (pre == PW'(CLKS_PER_US - 1));
  assign wrap     = tick & (frame_cnt == 15'(FRAME_US - 1));
  assign upd      = wrap & ctrl[0];
  assign pan_nxt  = slew(pan_cur, pan_tgt, step);
  assign tilt_nxt = slew(tilt_cur, tilt_tgt, step);
  assign pan_at   = (pan_cur == pan_tgt);
  assign tilt_at  = (tilt_cur == tilt_tgt);
  assign both_at  = pan_at & tilt_at;
  assign nxt_both = (pan_nxt == pan_tgt) & (tilt_nxt == tilt_tgt);
  assign done_set = upd & nxt_both & ~both_at;

  assign busy      = (state != IDLE);
  assign fire_tick = (fire_pre == PW'(CLKS_PER_US - 1));
  assign fire_req  = wr & (word == 6'd5) & PWDATA[0] & ctrl[1];
  // The abort looks at the write itself so FIRE_OUT drops on the write edge.
  assign abort     = ~ctrl[1] | (wr & (word == 6'd0) & ~PWDATA[1]);

  assign PAN_PWM  = pan_pwm;
  assign TILT_PWM = tilt_pwm;
  assign FIRE_OUT = (state == FIRING);
  assign IRQ      = done & ctrl[2];

  always_comb begin
    rdata = '0;
    case (word)
      6'd0:    rdata = {29'd0, ctrl};
      6'd1:    rdata = {16'd0, pan_tgt};
      6'd2:    rdata = {16'd0, tilt_tgt};
      6'd3:    rdata = {24'd0, step};
      6'd4:    rdata = {pan_cur, 12'd0, done, busy, tilt_at, pan_at};
      default: rdata = '0;
    endcase
    PRDATA = (PSEL & ~PWRITE) ? rdata : '0;
  end

  always_ff @(posedge FAB_CLK) begin
    if (FAB_RESET) begin
      ctrl      <= '0;
      pan_tgt   <= 16'(TGT_RST);
      tilt_tgt  <= 16'(TGT_RST);
      pan_cur   <= 16'(TGT_RST);
      tilt_cur  <= 16'(TGT_RST);
      step      <= 8'(STEP_RST);
      done      <= 1'b0;
      pre       <= '0;
      frame_cnt <= '0;
      pan_pwm   <= 1'b0;
      tilt_pwm  <= 1'b0;
    end else begin
      if (wr) begin
        case (word)
          6'd0:    ctrl     <= PWDATA[2:0];
          6'd1:    pan_tgt  <= clamp(PWDATA[15:0]);
          6'd2:    tilt_tgt <= clamp(PWDATA[15:0]);
          6'd3:    step     <= PWDATA[7:0];
          default: ;
        endcase
      end
      pre <= tick ? '0 : pre + 1'b1;
      if (tick) frame_cnt <= wrap ? '0 : frame_cnt + 1'b1;
      if (upd) begin
        pan_cur  <= pan_nxt;
        tilt_cur <= tilt_nxt;
      end
      if (done_set)
        done <= 1'b1;
      else if (wr && word == 6'd4 && PWDATA[3])
        done <= 1'b0;
      pan_pwm  <= ctrl[0] & ({1'b0, frame_cnt} < pan_cur);
      tilt_pwm <= ctrl[0] & ({1'b0, frame_cnt} < tilt_cur);
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:
        if (fire_req) state_nxt = FIRING;
      FIRING:
        if (abort || (fire_tick && fire_us == FUW'(FIRE_US - 1)))
          state_nxt = COOLDOWN;
      COOLDOWN:
        if (fire_tick && fire_us == FUW'(COOL_US - 1))
          state_nxt = IDLE;
      default:
        state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge FAB_CLK) begin
    if (FAB_RESET) begin
      state    <= IDLE;
      fire_pre <= '0;
      fire_us  <= '0;
    end else begin
      state <= state_nxt;
      if (state_nxt != state || state == IDLE) begin
        fire_pre <= '0;
        fire_us  <= '0;
      end else begin
        fire_pre <= fire_tick ? '0 : fire_pre + 1'b1;
        if (fire_tick) fire_us <= fire_us + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_turret_servo_ctrl.sv
// Scoreboard bench for turret_servo_ctrl with shrunken timing.
// Expected values are queued at stimulus time and popped at observation.
module tb_turret_servo_ctrl;

  logic        FAB_CLK = 1'b0;
  logic        FAB_RESET;
  logic        PSEL, PENABLE, PWRITE;
  logic [7:0]  PADDR;
  logic [31:0] PWDATA;
  logic [31:0] PRDATA;
  logic        PREADY, PSLVERR;
  logic        PAN_PWM, TILT_PWM, FIRE_OUT, IRQ;

  int vectors = 0;
  int miscompares = 0;
  logic [32:0] exp_q[$];

  localparam logic [7:0] A_CTRL = 8'h00;
  localparam logic [7:0] A_PAN  = 8'h04;
  localparam logic [7:0] A_TILT = 8'h08;
  localparam logic [7:0] A_STEP = 8'h0C;
  localparam logic [7:0] A_STAT = 8'h10;
  localparam logic [7:0] A_FIRE = 8'h14;

  turret_servo_ctrl #(
    .CLKS_PER_US(2), .FRAME_US(100), .MIN_US(10), .MAX_US(20),
    .FIRE_US(5), .COOL_US(8), .TGT_RST(15), .STEP_RST(10)
  ) dut (
    .FAB_CLK(FAB_CLK), .FAB_RESET(FAB_RESET),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA),
    .PREADY(PREADY), .PSLVERR(PSLVERR),
    .PAN_PWM(PAN_PWM), .TILT_PWM(TILT_PWM),
    .FIRE_OUT(FIRE_OUT), .IRQ(IRQ)
  );

  always #5 FAB_CLK = ~FAB_CLK;

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge FAB_CLK);
    #1;
  endtask

  task automatic apb_write(input logic [7:0] a, input logic [31:0] d);
    PSEL = 1'b1; PWRITE = 1'b1; PADDR = a; PWDATA = d; PENABLE = 1'b0;
    @(posedge FAB_CLK); #1;
    PENABLE = 1'b1;
    @(posedge FAB_CLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
  endtask

  task automatic apb_read(input logic [7:0] a, output logic [31:0] d,
                          output logic e);
    PSEL = 1'b1; PWRITE = 1'b0; PADDR = a; PENABLE = 1'b0;
    @(posedge FAB_CLK); #1;
    PENABLE = 1'b1;
    #1;
    d = PRDATA; e = PSLVERR;
    @(posedge FAB_CLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  task automatic wait_pan_rise(output bit ok);
    int n;
    n = 0;
    while (PAN_PWM && n < 1000) begin tick(1); n++; end
    n = 0;
    while (!PAN_PWM && n < 1000) begin tick(1); n++; end
    ok = PAN_PWM;
  endtask

  task automatic measure_pan(output int w);
    bit ok;
    w = -1;
    wait_pan_rise(ok);
    if (!ok) return;
    w = 0;
    while (PAN_PWM && w < 1000) begin w++; tick(1); end
  endtask

  task automatic test_reset;
    logic [7:0]  addrs [6];
    logic [31:0] exps [6];
    logic [31:0] d;
    logic        e;
    logic [32:0] x;
    addrs = '{A_CTRL, A_PAN, A_TILT, A_STEP, A_STAT, A_FIRE};
    exps  = '{32'd0, 32'd15, 32'd15, 32'd10, 32'h000F_0003, 32'd0};
    FAB_RESET = 1'b1;
    tick(3);
    FAB_RESET = 1'b0;
    vectors++;
    if ({PAN_PWM, TILT_PWM, FIRE_OUT, IRQ, PSLVERR, PREADY} !== 6'b000001) begin
      miscompares++;
      $display("FAIL reset_outs: got %b required 000001",
               {PAN_PWM, TILT_PWM, FIRE_OUT, IRQ, PSLVERR, PREADY});
    end
    for (int i = 0; i < 6; i++) begin
      exp_q.push_back({1'b0, exps[i]});
      apb_read(addrs[i], d, e);
      x = exp_q.pop_front();
      vectors++;
      if ({e, d} !== x) begin
        miscompares++;
        $display("FAIL reset_reg[%0h]: got %h required %h", addrs[i], {e, d}, x);
      end
    end
  endtask

  task automatic test_regs;
    logic [31:0] d;
    logic        e;
    logic [32:0] x;
    apb_write(A_PAN, 32'd25);
    exp_q.push_back({1'b0, 32'd20});
    apb_read(A_PAN, d, e);
    x = exp_q.pop_front(); vectors++;
    if ({e, d} !== x) begin
      miscompares++;
      $display("FAIL pan_clamp_hi: got %h required %h", {e, d}, x);
    end
    apb_write(A_TILT, 32'd3);
    exp_q.push_back({1'b0, 32'd10});
    apb_read(A_TILT, d, e);
    x = exp_q.pop_front(); vectors++;
    if ({e, d} !== x) begin
      miscompares++;
      $display("FAIL tilt_clamp_lo: got %h required %h", {e, d}, x);
    end
    apb_write(8'h18, 32'h0000_000C);
    exp_q.push_back({1'b1, 32'd0});
    apb_read(8'h18, d, e);
    x = exp_q.pop_front(); vectors++;
    if ({e, d} !== x) begin
      miscompares++;
      $display("FAIL unmapped_rd: got %h required %h", {e, d}, x);
    end
    exp_q.push_back({1'b0, 32'd20});
    apb_read(A_PAN, d, e);
    x = exp_q.pop_front(); vectors++;
    if ({e, d} !== x) begin
      miscompares++;
      $display("FAIL unmapped_wr_noeffect: got %h required %h", {e, d}, x);
    end
    apb_write(A_PAN, 32'd15);
    apb_write(A_TILT, 32'd15);
  endtask

  task automatic test_slew;
    int          w;
    logic [31:0] d;
    logic        e;
    logic [32:0] x;
    apb_write(A_STEP, 32'd3);
    apb_write(A_PAN, 32'd20);
    apb_write(A_CTRL, 32'd1);
    tick(1);
    exp_q.push_back(33'd36);
    measure_pan(w);
    x = exp_q.pop_front(); vectors++;
    if ($signed(w) !== $signed(x[31:0])) begin
      miscompares++;
      $display("FAIL slew_pulse1: got %0d required %0d", w, x);
    end
    exp_q.push_back({1'b0, 32'h0012_0002});
    apb_read(A_STAT, d, e);
    x = exp_q.pop_front(); vectors++;
    if ({e, d} !== x) begin
      miscompares++;
      $display("FAIL slew_status1: got %h required %h", {e, d}, x);
    end
    exp_q.push_back(33'd40);
    measure_pan(w);
    x = exp_q.pop_front(); vectors++;
    if ($signed(w) !== $signed(x[31:0])) begin
      miscompares++;
      $display("FAIL slew_pulse2: got %0d required %0d", w, x);
    end
    exp_q.push_back({1'b0, 32'h0014_000B});
    apb_read(A_STAT, d, e);
    x = exp_q.pop_front(); vectors++;
    if ({e, d} !== x) begin
      miscompares++;
      $display("FAIL slew_status2: got %h required %h", {e, d}, x);
    end
    vectors++;
    if (IRQ !== 1'b0) begin
      miscompares++;
      $display("FAIL irq_masked: got %b required 0", IRQ);
    end
  endtask

  task automatic test_done_irq;
    bit          ok;
    logic [31:0] d;
    logic        e;
    logic [32:0] x;
    apb_write(A_CTRL, 32'd5);
    vectors++;
    if (IRQ !== 1'b1) begin
      miscompares++;
      $display("FAIL irq_set: got %b required 1", IRQ);
    end
    apb_write(A_STAT, 32'd8);
    vectors++;
    if (IRQ !== 1'b0) begin
      miscompares++;
      $display("FAIL irq_clear: got %b required 0", IRQ);
    end
    wait_pan_rise(ok);
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL done_align: got no pulse required pulse");
    end
    apb_write(A_PAN, 32'd17);
    tick(195);
    apb_write(A_STAT, 32'd8);
    exp_q.push_back({1'b0, 32'h0011_000B});
    apb_read(A_STAT, d, e);
    x = exp_q.pop_front(); vectors++;
    if ({e, d} !== x) begin
      miscompares++;
      $display("FAIL done_set_wins: got %h required %h", {e, d}, x);
    end
    vectors++;
    if (IRQ !== 1'b1) begin
      miscompares++;
      $display("FAIL irq_set_wins: got %b required 1", IRQ);
    end
    apb_write(A_STAT, 32'd8);
  endtask

  task automatic test_fire;
    int hi, bz;
    apb_write(A_CTRL, 32'd7);
    apb_write(A_FIRE, 32'd1);
    PSEL = 1'b1; PWRITE = 1'b0; PADDR = A_STAT; PENABLE = 1'b1;
    #1;
    hi = 0; bz = 0;
    for (int i = 0; i < 60; i++) begin
      if (FIRE_OUT) hi++;
      else if (PRDATA[2]) bz++;
      tick(1);
    end
    PSEL = 1'b0; PENABLE = 1'b0;
    exp_q.push_back(33'd10);
    vectors++;
    if (hi !== int'(exp_q.pop_front())) begin
      miscompares++;
      $display("FAIL fire_width: got %0d required 10", hi);
    end
    exp_q.push_back(33'd16);
    vectors++;
    if (bz !== int'(exp_q.pop_front())) begin
      miscompares++;
      $display("FAIL cool_width: got %0d required 16", bz);
    end
  endtask

  task automatic test_fire_ignored;
    logic [31:0] d;
    logic        e;
    apb_write(A_FIRE, 32'd1);
    tick(11);
    apb_write(A_FIRE, 32'd1);
    vectors++;
    if (FIRE_OUT !== 1'b0) begin
      miscompares++;
      $display("FAIL refire_cool: got %b required 0", FIRE_OUT);
    end
    apb_read(A_STAT, d, e);
    vectors++;
    if (d[2] !== 1'b1) begin
      miscompares++;
      $display("FAIL cool_busy: got %b required 1", d[2]);
    end
    tick(12);
    apb_read(A_STAT, d, e);
    vectors++;
    if ({d[2], FIRE_OUT} !== 2'b00) begin
      miscompares++;
      $display("FAIL refire_idle: got %b required 00", {d[2], FIRE_OUT});
    end
    apb_write(A_CTRL, 32'd5);
    apb_write(A_FIRE, 32'd1);
    apb_read(A_STAT, d, e);
    vectors++;
    if ({d[2], FIRE_OUT} !== 2'b00) begin
      miscompares++;
      $display("FAIL fire_unarmed: got %b required 00", {d[2], FIRE_OUT});
    end
  endtask

  task automatic test_abort;
    logic [31:0] d;
    logic        e;
    apb_write(A_CTRL, 32'd7);
    apb_write(A_FIRE, 32'd1);
    vectors++;
    if (FIRE_OUT !== 1'b1) begin
      miscompares++;
      $display("FAIL fire_rise: got %b required 1", FIRE_OUT);
    end
    tick(3);
    apb_write(A_CTRL, 32'd5);
    vectors++;
    if (FIRE_OUT !== 1'b0) begin
      miscompares++;
      $display("FAIL abort_fall: got %b required 0", FIRE_OUT);
    end
    apb_read(A_STAT, d, e);
    vectors++;
    if (d[2] !== 1'b1) begin
      miscompares++;
      $display("FAIL abort_cool: got %b required 1", d[2]);
    end
    tick(20);
    apb_read(A_STAT, d, e);
    vectors++;
    if (d[2] !== 1'b0) begin
      miscompares++;
      $display("FAIL abort_idle: got %b required 0", d[2]);
    end
  endtask

  task automatic test_reset_mid;
    bit          ok;
    logic [7:0]  addrs [5];
    logic [31:0] exps [5];
    logic [31:0] d;
    logic        e;
    logic [32:0] x;
    addrs = '{A_CTRL, A_PAN, A_TILT, A_STEP, A_STAT};
    exps  = '{32'd0, 32'd15, 32'd15, 32'd10, 32'h000F_0003};
    apb_write(A_CTRL, 32'd7);
    wait_pan_rise(ok);
    apb_write(A_FIRE, 32'd1);
    tick(2);
    vectors++;
    if ({ok, PAN_PWM, FIRE_OUT} !== 3'b111) begin
      miscompares++;
      $display("FAIL pre_reset: got %b required 111", {ok, PAN_PWM, FIRE_OUT});
    end
    FAB_RESET = 1'b1;
    tick(1);
    vectors++;
    if ({PAN_PWM, TILT_PWM, FIRE_OUT, IRQ, PSLVERR, PRDATA} !== 37'd0) begin
      miscompares++;
      $display("FAIL mid_reset_outs: got %h required 0",
               {PAN_PWM, TILT_PWM, FIRE_OUT, IRQ, PSLVERR, PRDATA});
    end
    FAB_RESET = 1'b0;
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back({1'b0, exps[i]});
      apb_read(addrs[i], d, e);
      x = exp_q.pop_front(); vectors++;
      if ({e, d} !== x) begin
        miscompares++;
        $display("FAIL mid_reset_reg[%0h]: got %h required %h", addrs[i], {e, d}, x);
      end
    end
  endtask

  task automatic test_en_off;
    bit          ok;
    int          hi, w;
    logic [31:0] d;
    logic        e;
    logic [32:0] x;
    apb_write(A_STEP, 32'd3);
    apb_write(A_PAN, 32'd20);
    apb_write(A_CTRL, 32'd1);
    tick(1);
    wait_pan_rise(ok);
    tick(10);
    apb_write(A_CTRL, 32'd0);
    tick(1);
    vectors++;
    if ({ok, PAN_PWM, TILT_PWM} !== 3'b100) begin
      miscompares++;
      $display("FAIL en_off_drop: got %b required 100", {ok, PAN_PWM, TILT_PWM});
    end
    hi = 0;
    for (int i = 0; i < 300; i++) begin
      if (PAN_PWM || TILT_PWM) hi++;
      tick(1);
    end
    vectors++;
    if (hi !== 0) begin
      miscompares++;
      $display("FAIL en_off_quiet: got %0d required 0", hi);
    end
    exp_q.push_back({1'b0, 32'h0012_0002});
    apb_read(A_STAT, d, e);
    x = exp_q.pop_front(); vectors++;
    if ({e, d} !== x) begin
      miscompares++;
      $display("FAIL en_off_hold: got %h required %h", {e, d}, x);
    end
    apb_write(A_PAN, 32'd18);
    apb_write(A_CTRL, 32'd1);
    tick(1);
    exp_q.push_back(33'd36);
    measure_pan(w);
    x = exp_q.pop_front(); vectors++;
    if ($signed(w) !== $signed(x[31:0])) begin
      miscompares++;
      $display("FAIL reenable_pulse: got %0d required %0d", w, x);
    end
    exp_q.push_back({1'b0, 32'h0012_0003});
    apb_read(A_STAT, d, e);
    x = exp_q.pop_front(); vectors++;
    if ({e, d} !== x) begin
      miscompares++;
      $display("FAIL reenable_nodone: got %h required %h", {e, d}, x);
    end
  endtask

  initial begin
    FAB_RESET = 1'b1;
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    PADDR = '0; PWDATA = '0;
    tick(2);
    test_reset();
    test_regs();
    test_slew();
    test_done_irq();
    test_fire();
    test_fire_ignored();
    test_abort();
    test_reset_mid();
    test_en_off();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
